// File: rtl/segmented_display_pkg.sv
// segmented_display_pkg: shared glyph table, FSM state type and default
// settle length for the segmented display decoder.
package segmented_display_pkg;

    // Settle/latch states of the input sampler
    typedef enum logic {
        SETTLING = 1'b0,
        LATCHED  = 1'b1
    } decoderState_e;

    localparam int DEFAULT_SETTLE_CYCLES = 16;

    // Active-high segment patterns (bit0=a ... bit6=g), index = hex digit
    localparam logic [15:0][6:0] GLYPH_TABLE = {
        7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
        7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
    };

endpackage

// File: rtl/seven_segment_to_hex.sv
// seven_segment_to_hex: combinational reverse lookup of an active-high
// seven-segment pattern into its hex nybble; flags patterns not in the table.
module seven_segment_to_hex
    import segmented_display_pkg::*;
(
    input  logic [6:0] i_pattern,
    output logic [3:0] o_nybble,
    output logic       o_unknown
);

    // Search the glyph table; unmatched patterns decode as 0 with the flag set
    always_comb begin
        o_nybble  = 4'h0;
        o_unknown = 1'b1;
        for (int k = 0; k < 16; k++) begin
            if (i_pattern == GLYPH_TABLE[k]) begin
                o_nybble  = 4'(k);
                o_unknown = 1'b0;
            end
        end
    end

endmodule

// File: rtl/segmented_display_decoder.sv
// segmented_display_decoder: snoops a multiplexed seven-segment display
// (anode digit selects, cathode segments, decimal point), waits for each
// digit to settle, decodes it back to hex and publishes a full frame once
// every digit has been seen.
// Optional feature: define SEGMENTED_DISPLAY_DECODER_TIMEOUT_EN to add a
// 24-bit watchdog that drops a stalled partial frame.
module segmented_display_decoder
    import segmented_display_pkg::*;
#(
    parameter int   NUMBER_OF_SEGMENTS   = 7,
    parameter int   NUMBER_OF_NYBBLES    = 4,
    parameter int   SETTLE_CYCLES        = DEFAULT_SETTLE_CYCLES,
    parameter logic ANODE_ACTIVE_LEVEL   = 1'b1,
    parameter logic CATHODE_ACTIVE_LEVEL = 1'b0
)
(
    input  logic                           clock,
    input  logic                           reset,
    input  logic [NUMBER_OF_NYBBLES-1:0]   anode,
    input  logic [NUMBER_OF_SEGMENTS-1:0]  cathode,
    input  logic                           dp_in,
    output logic [4*NUMBER_OF_NYBBLES-1:0] data,
    output logic [NUMBER_OF_NYBBLES-1:0]   dp,
    output logic                           valid,
    output logic                           glyph_error,
    output logic                           anode_error
);

    localparam int N        = NUMBER_OF_NYBBLES;
    localparam int SAMPLE_W = NUMBER_OF_NYBBLES + NUMBER_OF_SEGMENTS + 1;
    localparam int IDX_W    = (N > 1) ? $clog2(N) : 1;

    logic [N-1:0]                  r_anodeMeta, r_anodeSync;
    logic [NUMBER_OF_SEGMENTS-1:0] r_cathodeMeta, r_cathodeSync;
    logic                          r_dpMeta, r_dpSync;
    logic [SAMPLE_W-1:0]           r_prevSample;
    logic [15:0]                   r_settleCount;
    decoderState_e                 r_state;

    logic [N-1:0][3:0]             r_digits;
    logic [N-1:0]                  r_dps;
    logic [N-1:0]                  r_seen;
    logic [4*N-1:0]                r_data;
    logic [N-1:0]                  r_dp;
    logic                          r_valid, r_glyphError, r_anodeError;

    logic [N-1:0]                  w_anodeNorm;
    logic [NUMBER_OF_SEGMENTS-1:0] w_cathodeNorm;
    logic                          w_dpNorm;
    logic [SAMPLE_W-1:0]           w_sample;
    logic                          w_sampleChanged;
    decoderState_e                 w_nextState;
    logic [15:0]                   w_nextCount;
    logic                          w_capture, w_store;
    logic                          w_anyActive, w_multiActive;
    logic [IDX_W-1:0]              w_activeIndex;
    logic [3:0]                    w_nybble;
    logic                          w_unknown;
    logic [N-1:0]                  w_seenNext;
    logic                          w_frameDone;
    logic                          w_timeout;

    // Two-flop synchronisers on every asynchronous display line
    always_ff @(posedge clock) begin
        if (reset) begin
            r_anodeMeta   <= '0;
            r_anodeSync   <= '0;
            r_cathodeMeta <= '0;
            r_cathodeSync <= '0;
            r_dpMeta      <= 1'b0;
            r_dpSync      <= 1'b0;
        end else begin
            r_anodeMeta   <= anode;
            r_anodeSync   <= r_anodeMeta;
            r_cathodeMeta <= cathode;
            r_cathodeSync <= r_cathodeMeta;
            r_dpMeta      <= dp_in;
            r_dpSync      <= r_dpMeta;
        end
    end

    assign w_anodeNorm     = r_anodeSync ^ {N{~ANODE_ACTIVE_LEVEL}};
    assign w_cathodeNorm   = r_cathodeSync ^ {NUMBER_OF_SEGMENTS{~CATHODE_ACTIVE_LEVEL}};
    assign w_dpNorm        = r_dpSync ^ ~CATHODE_ACTIVE_LEVEL;
    assign w_sample        = {r_anodeSync, r_cathodeSync, r_dpSync};
    assign w_sampleChanged = (w_sample != r_prevSample);

    // Classify the settled anode vector: blank, one-hot (with index) or multiple
    always_comb begin
        w_anyActive   = 1'b0;
        w_multiActive = 1'b0;
        w_activeIndex = '0;
        for (int k = 0; k < N; k++) begin
            if (w_anodeNorm[k]) begin
                if (w_anyActive) begin
                    w_multiActive = 1'b1;
                end
                w_anyActive   = 1'b1;
                w_activeIndex = IDX_W'(k);
            end
        end
    end

    seven_segment_to_hex u_lookup (
        .i_pattern (w_cathodeNorm[6:0]),
        .o_nybble  (w_nybble),
        .o_unknown (w_unknown)
    );

    // Settle FSM state, stability counter and previous-sample registers
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state       <= SETTLING;
            r_settleCount <= '0;
            r_prevSample  <= '0;
        end else begin
            r_state       <= w_nextState;
            r_settleCount <= w_nextCount;
            r_prevSample  <= w_sample;
        end
    end

    // Next state: capture fires on the sample that completes the stable run
    always_comb begin
        w_nextState = r_state;
        w_nextCount = r_settleCount;
        w_capture   = 1'b0;
        case (r_state)
            SETTLING: begin
                if (w_sampleChanged) begin
                    w_nextCount = '0;
                end else if (r_settleCount == 16'(SETTLE_CYCLES - 2)) begin
                    w_nextCount = r_settleCount + 16'd1;
                    w_nextState = LATCHED;
                    w_capture   = 1'b1;
                end else begin
                    w_nextCount = r_settleCount + 16'd1;
                end
            end
            LATCHED: begin
                if (w_sampleChanged) begin
                    w_nextState = SETTLING;
                    w_nextCount = '0;
                end
            end
            default: begin
                w_nextState = SETTLING;
                w_nextCount = '0;
            end
        endcase
    end

    assign w_store     = w_capture && w_anyActive && !w_multiActive;
    assign w_frameDone = &r_seen;

    // Seen mask: frame copy or timeout clears it, a same-cycle capture re-sets its bit
    always_comb begin
        w_seenNext = r_seen;
        if (w_frameDone || w_timeout) begin
            w_seenNext = '0;
        end
        if (w_store) begin
            w_seenNext[w_activeIndex] = 1'b1;
        end
    end

`ifdef SEGMENTED_DISPLAY_DECODER_TIMEOUT_EN
    logic [23:0] r_watchdog;

    // Watchdog runs only while a partial frame is pending
    always_ff @(posedge clock) begin
        if (reset) begin
            r_watchdog <= '0;
        end else if (w_store || (r_seen == '0) || w_timeout) begin
            r_watchdog <= '0;
        end else begin
            r_watchdog <= r_watchdog + 24'd1;
        end
    end

    assign w_timeout = (r_watchdog == 24'hFFFFFF) && !w_frameDone;
`else
    assign w_timeout = 1'b0;
`endif

    // Digit capture, error pulses and frame publication
    always_ff @(posedge clock) begin
        if (reset) begin
            r_digits     <= '0;
            r_dps        <= '0;
            r_seen       <= '0;
            r_data       <= '0;
            r_dp         <= '0;
            r_valid      <= 1'b0;
            r_glyphError <= 1'b0;
            r_anodeError <= 1'b0;
        end else begin
            r_valid      <= 1'b0;
            r_glyphError <= 1'b0;
            r_anodeError <= 1'b0;
            r_seen       <= w_seenNext;
            if (w_frameDone) begin
                r_data  <= r_digits;
                r_dp    <= r_dps;
                r_valid <= 1'b1;
            end
            if (w_timeout) begin
                r_data <= '0;
            end
            if (w_capture && w_multiActive) begin
                r_anodeError <= 1'b1;
            end
            if (w_store) begin
                r_digits[w_activeIndex] <= w_nybble;
                r_dps[w_activeIndex]    <= w_dpNorm;
                r_glyphError            <= w_unknown;
            end
        end
    end

    assign data        = r_data;
    assign dp          = r_dp;
    assign valid       = r_valid;
    assign glyph_error = r_glyphError;
    assign anode_error = r_anodeError;

endmodule

// File: tb/tb_segmented_display_decoder.sv
// tb_segmented_display_decoder: scenario tasks drive a simulated multiplexed
// display; expected frames are queued as scans are driven and matched
// against every valid pulse by a monitor.
module tb_segmented_display_decoder;

    localparam int SETTLE = 4;
    localparam int DWELL  = 20;

    logic        clock = 1'b0;
    logic        reset;
    logic [3:0]  anode;
    logic [6:0]  cathode;
    logic        dp_in;
    logic [15:0] data;
    logic [3:0]  dp;
    logic        valid;
    logic        glyph_error;
    logic        anode_error;

    localparam logic [6:0] SEG [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    logic [19:0] expQ [$];
    int compared    = 0;
    int mismatched  = 0;
    int validCount  = 0;
    int glyphCount  = 0;
    int anodeCount  = 0;

    segmented_display_decoder #(
        .NUMBER_OF_SEGMENTS   (7),
        .NUMBER_OF_NYBBLES    (4),
        .SETTLE_CYCLES        (SETTLE),
        .ANODE_ACTIVE_LEVEL   (1'b1),
        .CATHODE_ACTIVE_LEVEL (1'b0)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .anode       (anode),
        .cathode     (cathode),
        .dp_in       (dp_in),
        .data        (data),
        .dp          (dp),
        .valid       (valid),
        .glyph_error (glyph_error),
        .anode_error (anode_error)
    );

    always #5 clock = ~clock;

    // Monitor: every valid pulse is checked against the oldest queued frame
    always @(negedge clock) begin
        logic [19:0] expFrame;
        if (valid) begin
            validCount++;
            compared++;
            if (expQ.size() == 0) begin
                mismatched++;
                $display("[TB] FAIL frame: unexpected valid, data=%h dp=%h, none expected", data, dp);
            end else begin
                expFrame = expQ.pop_front();
                if ({data, dp} !== expFrame) begin
                    mismatched++;
                    $display("[TB] FAIL frame: got data=%h dp=%h, expected data=%h dp=%h",
                             data, dp, expFrame[19:4], expFrame[3:0]);
                end
            end
        end
        if (glyph_error) glyphCount++;
        if (anode_error) anodeCount++;
    end

    // Show one digit (active-high pattern) for a dwell, optionally preceded by glitches
    task automatic applyStimulus(input logic [3:0] an, input logic [6:0] pattern,
                                 input logic dpBit, input bit glitch);
        if (glitch) begin
            for (int g = 0; g < 3; g++) begin
                @(negedge clock);
                anode   = an;
                cathode = 7'($urandom_range(0, 127));
                dp_in   = 1'($urandom_range(0, 1));
            end
        end
        @(negedge clock);
        anode   = an;
        cathode = ~pattern;
        dp_in   = ~dpBit;
        repeat (DWELL) @(negedge clock);
    endtask

    task automatic applyIdle(input int cycles);
        @(negedge clock);
        anode   = 4'h0;
        cathode = 7'h7F;
        dp_in   = 1'b1;
        repeat (cycles) @(negedge clock);
    endtask

    task automatic scanDigits(input logic [15:0] value, input logic [3:0] dps,
                              input int first, input int last, input bit glitch);
        for (int d = first; d <= last; d++) begin
            applyStimulus(4'(1 << d), SEG[value[4*d +: 4]], dps[d], glitch);
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        applyIdle(3);
        compared++; if (data !== 16'h0) begin mismatched++; $display("[TB] FAIL reset_data: got %h expected 0000", data); end
        compared++; if (dp !== 4'h0) begin mismatched++; $display("[TB] FAIL reset_dp: got %h expected 0", dp); end
        compared++; if (valid !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_valid: got %b expected 0", valid); end
        compared++; if (glyph_error !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_glyph: got %b expected 0", glyph_error); end
        compared++; if (anode_error !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_anode: got %b expected 0", anode_error); end
        reset = 1'b0;
        applyIdle(5);
    endtask

    task automatic test_scan;
        int v0, g0, a0;
        v0 = validCount; g0 = glyphCount; a0 = anodeCount;
        expQ.push_back({16'h1A3F, 4'h0});
        scanDigits(16'h1A3F, 4'h0, 0, 3, 1'b0);
        compared++; if (validCount - v0 != 1) begin mismatched++; $display("[TB] FAIL scan1_valid_count: got %0d expected 1", validCount - v0); end
        compared++; if (data !== 16'h1A3F) begin mismatched++; $display("[TB] FAIL scan1_data: got %h expected 1a3f", data); end
        expQ.push_back({16'h80C7, 4'b0101});
        scanDigits(16'h80C7, 4'b0101, 0, 3, 1'b0);
        compared++; if (validCount - v0 != 2) begin mismatched++; $display("[TB] FAIL scan2_valid_count: got %0d expected 2", validCount - v0); end
        compared++; if (glyphCount != g0) begin mismatched++; $display("[TB] FAIL scan_glyph_err: got %0d pulses expected 0", glyphCount - g0); end
        compared++; if (anodeCount != a0) begin mismatched++; $display("[TB] FAIL scan_anode_err: got %0d pulses expected 0", anodeCount - a0); end
    endtask

    task automatic test_glitch;
        int v0;
        v0 = validCount;
        expQ.push_back({16'hBEEF, 4'b1000});
        scanDigits(16'hBEEF, 4'b1000, 0, 3, 1'b1);
        compared++; if (validCount - v0 != 1) begin mismatched++; $display("[TB] FAIL glitch_valid_count: got %0d expected 1", validCount - v0); end
        compared++; if (data !== 16'hBEEF) begin mismatched++; $display("[TB] FAIL glitch_data: got %h expected beef", data); end
    endtask

    task automatic test_latency;
        int lat;
        lat = 0;
        expQ.push_back({16'h2468, 4'h0});
        scanDigits(16'h2468, 4'h0, 0, 2, 1'b0);
        @(negedge clock);
        anode   = 4'b1000;
        cathode = ~SEG[2];
        dp_in   = 1'b1;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clock);
            if (valid && lat == 0) lat = c;
        end
        compared++; if (lat != SETTLE + 3) begin mismatched++; $display("[TB] FAIL latency: got %0d cycles expected %0d (0 = timed out)", lat, SETTLE + 3); end
    endtask

    task automatic test_anode_error;
        int v0, a0;
        v0 = validCount; a0 = anodeCount;
        expQ.push_back({16'h5A96, 4'b0010});
        scanDigits(16'h5A96, 4'b0010, 0, 1, 1'b0);
        applyStimulus(4'b0110, SEG[8], 1'b0, 1'b0);
        compared++; if (anodeCount - a0 != 1) begin mismatched++; $display("[TB] FAIL anode_error_pulses: got %0d expected 1", anodeCount - a0); end
        scanDigits(16'h5A96, 4'b0010, 2, 3, 1'b0);
        compared++; if (validCount - v0 != 1) begin mismatched++; $display("[TB] FAIL anode_error_valid_count: got %0d expected 1", validCount - v0); end
    endtask

    task automatic test_glyph_error;
        int g0;
        g0 = glyphCount;
        expQ.push_back({16'h90CD, 4'h0});
        scanDigits(16'h90CD, 4'h0, 0, 1, 1'b0);
        applyStimulus(4'b0100, 7'h00, 1'b0, 1'b0);
        compared++; if (glyphCount - g0 != 1) begin mismatched++; $display("[TB] FAIL glyph_error_pulses: got %0d expected 1", glyphCount - g0); end
        scanDigits(16'h90CD, 4'h0, 3, 3, 1'b0);
        compared++; if (data[11:8] !== 4'h0) begin mismatched++; $display("[TB] FAIL glyph_digit2: got %h expected 0", data[11:8]); end
    endtask

    task automatic test_back_to_back;
        expQ.push_back({16'h3E51, 4'h0});
        applyStimulus(4'b0001, SEG[1], 1'b0, 1'b0);
        applyStimulus(4'b0010, SEG[2], 1'b0, 1'b0);
        applyStimulus(4'b0010, SEG[5], 1'b0, 1'b0);
        applyStimulus(4'b0100, SEG[14], 1'b0, 1'b0);
        applyStimulus(4'b1000, SEG[3], 1'b0, 1'b0);
        compared++; if (data !== 16'h3E51) begin mismatched++; $display("[TB] FAIL overwrite_data: got %h expected 3e51", data); end
    endtask

    task automatic test_hold;
        int v0;
        v0 = validCount;
        expQ.push_back({16'h4321, 4'h0});
        scanDigits(16'h4321, 4'h0, 0, 2, 1'b0);
        applyIdle(200);
        compared++; if (validCount != v0) begin mismatched++; $display("[TB] FAIL hold_no_valid: got %0d pulses expected 0", validCount - v0); end
        compared++; if (data !== 16'h3E51) begin mismatched++; $display("[TB] FAIL hold_data: got %h expected 3e51", data); end
        scanDigits(16'h4321, 4'h0, 3, 3, 1'b0);
        compared++; if (validCount - v0 != 1) begin mismatched++; $display("[TB] FAIL hold_resume_valid: got %0d expected 1", validCount - v0); end
    endtask

    task automatic test_reset_mid_frame;
        int v0;
        v0 = validCount;
        scanDigits(16'h9999, 4'h0, 0, 1, 1'b0);
        applyIdle(5);
        reset = 1'b1;
        repeat (3) @(negedge clock);
        compared++; if (data !== 16'h0) begin mismatched++; $display("[TB] FAIL midreset_data: got %h expected 0000", data); end
        compared++; if (dp !== 4'h0) begin mismatched++; $display("[TB] FAIL midreset_dp: got %h expected 0", dp); end
        reset = 1'b0;
        applyIdle(5);
        expQ.push_back({16'h6B2D, 4'hF});
        scanDigits(16'h6B2D, 4'hF, 0, 3, 1'b0);
        compared++; if (validCount - v0 != 1) begin mismatched++; $display("[TB] FAIL midreset_valid_count: got %0d expected 1", validCount - v0); end
    endtask

    // Scenario sequence and summary
    initial begin
        reset   = 1'b1;
        anode   = 4'h0;
        cathode = 7'h7F;
        dp_in   = 1'b1;
        test_reset();
        test_scan();
        test_glitch();
        test_latency();
        test_anode_error();
        test_glyph_error();
        test_back_to_back();
        test_hold();
        test_reset_mid_frame();
        applyIdle(10);
        compared++;
        if (expQ.size() != 0) begin
            mismatched++;
            $display("[TB] FAIL frames_outstanding: got %0d expected 0", expQ.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/segmented_display_decoder.md
SEGMENTED_DISPLAY_DECODER -- requirements
Module: segmented_display_decoder

Interface
REQ-001 Parameter NUMBER_OF_SEGMENTS, default 7, SHALL be the cathode bus width; only 7 is supported.
REQ-002 Parameter NUMBER_OF_NYBBLES, default 4, SHALL be the anode/digit count.
REQ-003 Parameter SETTLE_CYCLES, default 16, SHALL be the consecutive stable samples required before a digit is captured; legal range 2..65535.
REQ-004 Parameter ANODE_ACTIVE_LEVEL, default 1, and CATHODE_ACTIVE_LEVEL, default 0, SHALL define the lit level of each line.
REQ-005 Ports: clock  in  1  sole clock; all logic on its rising edge.
REQ-006 Ports: reset  in  1  synchronous, active-high.
REQ-007 Ports: anode  in  NUMBER_OF_NYBBLES  asynchronous digit-select lines; bit 0 is the least significant digit.
REQ-008 Ports: cathode  in  NUMBER_OF_SEGMENTS  asynchronous segment lines; bit0=a ... bit6=g.
REQ-009 Ports: dp_in  in  1  asynchronous decimal-point line, same polarity as cathode.
REQ-010 Ports: data  out  4*NUMBER_OF_NYBBLES  last complete decoded frame.
REQ-011 Ports: dp  out  NUMBER_OF_NYBBLES  decimal points of the last frame.
REQ-012 Ports: valid  out  1  one-cycle pulse when data/dp update.
REQ-013 Ports: glyph_error  out  1  one-cycle pulse on an unrecognised segment pattern.
REQ-014 Ports: anode_error  out  1  one-cycle pulse when a settled anode vector has more than one line active.

Function
REQ-015 anode, cathode and dp_in SHALL each pass through a 2-flop synchroniser; all further logic SHALL use the synchronised values only.
REQ-016 Inputs SHALL be normalised to active-high using the ANODE_ACTIVE_LEVEL and CATHODE_ACTIVE_LEVEL parameters.
REQ-017 FSM states SHALL be SETTLING and LATCHED.
  - SETTLING: a 16-bit counter increments while the sample equals the previous sample, and clears to 0 on any difference.
  - SETTLING -> LATCHED: when the counter reaches SETTLE_CYCLES-1.
  - LATCHED -> SETTLING: on any sample change, with the counter cleared.
REQ-018 On the SETTLING->LATCHED transition, the settled anode vector SHALL be evaluated.
  - Exactly one bit set at index i: decode the glyph into digit register i, store dp bit i, set seen[i].
  - Zero bits set: blanking; no action.
  - More than one bit set: pulse anode_error; store nothing.
REQ-019 Decoding SHALL use the package glyph table (active-high):
  - 0-7: 3F 06 5B 4F 66 6D 7D 07
  - 8-F: 7F 6F 77 7C 39 5E 79 71
REQ-020 A pattern not in the glyph table SHALL store nybble 0, set seen[i], and pulse glyph_error in the same cycle.
REQ-021 A digit SHALL be captured at most once per anode dwell; re-capture requires a sample change followed by a fresh settle.
REQ-022 The cycle after seen reaches all-ones, the module SHALL:
  - copy the digit registers to data and the dp bits to dp;
  - pulse valid;
  - clear seen.
REQ-023 A capture that coincides with the frame-copy cycle SHALL land in the next frame, with its seen bit set after the clear.
REQ-024 Repeated capture of the same digit before the frame completes SHALL overwrite that digit; the last value wins.
REQ-025 Latency SHALL be 2 sync cycles + SETTLE_CYCLES + 1 from the last digit becoming stable to valid.

Reset
REQ-026 While reset is high, the module SHALL clear:
  - data, dp, valid, glyph_error, anode_error, seen, digit registers and the counter;
  - the synchronisers;
  - the FSM, which SHALL enter SETTLING.
REQ-027 A reset mid-frame SHALL discard partial digits; the first valid after reset requires all NUMBER_OF_NYBBLES digits to be recaptured.

Configuration
REQ-028 Macro SEGMENTED_DISPLAY_DECODER_TIMEOUT_EN SHALL enable a 24-bit watchdog.
  - The watchdog clears on every capture.
  - Reaching 2^24-1 SHALL clear seen and data, with no valid pulse.
  - Without the macro, the watchdog SHALL be absent, and partial frames SHALL be held indefinitely.

Structure
REQ-029 Package segmented_display_pkg SHALL hold the 16-entry glyph table constant, the FSM state typedef and the default SETTLE_CYCLES constant.
REQ-030 Sub-module seven_segment_to_hex (combinational: 7-bit pattern in; nybble and unknown flag out) SHALL perform glyph lookup.

Verification
REQ-031 Scan the digits of 16'h1A3F with SETTLE_CYCLES=4 and a 20-cycle dwell per digit -> valid pulses once per scan, data=16'h1A3F, dp=4'h0.
REQ-032 Apply 3 cycles of random cathode glitch before each stable dwell -> no early capture; data stays correct.
REQ-033 Set anode=4'b0110 stable for 20 cycles -> anode_error pulses once; seen is unchanged.
REQ-034 Put cathode pattern 0x00 (lit) on digit 2 -> glyph_error pulses once; after the frame completes, data[11:8]=0.
REQ-035 Assert reset after 2 of 4 digits, then run a full scan -> exactly one valid, carrying only post-reset digits.
REQ-036 With TIMEOUT_EN, capture 3 digits and then hold anode=0 for 2^24 cycles -> data=0, no valid; without the macro -> data is unchanged.
